// File: rtl/fib_sweep_ctrl.sv
// Sweeps n over [n_first, n_last], issuing one Fibonacci core request per n
// and streaming each (n, result, overflow) tuple out over a valid/ready port.
module fib_sweep_ctrl #(
    parameter int INPUT_WIDTH    = 6,
    parameter int OUTPUT_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int STOP_ON_OVF    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [INPUT_WIDTH-1:0]  n_first,
    input  logic [INPUT_WIDTH-1:0]  n_last,
    output logic                    busy,
    output logic                    sweep_done,
    output logic                    err_timeout,
    output logic [INPUT_WIDTH:0]    out_count,
    output logic                    calc_go,
    output logic [INPUT_WIDTH-1:0]  calc_n,
    input  logic [OUTPUT_WIDTH-1:0] calc_result,
    input  logic                    calc_overflow,
    input  logic                    calc_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INPUT_WIDTH-1:0]  out_n,
    output logic [OUTPUT_WIDTH-1:0] out_result,
    output logic                    out_overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = INPUT_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, EMIT} state_e;

    state_e                  state_q, state_d;
    logic [INPUT_WIDTH-1:0]  cur_n_q, cur_n_d;
    logic [INPUT_WIDTH-1:0]  last_n_q, last_n_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    out_valid_q, out_valid_d;
    logic [INPUT_WIDTH-1:0]  out_n_q, out_n_d;
    logic [OUTPUT_WIDTH-1:0] out_result_q, out_result_d;
    logic                    out_overflow_q, out_overflow_d;
    logic [CW-1:0]           out_count_q, out_count_d;
    logic                    err_timeout_q, err_timeout_d;
    logic                    sweep_done_q, sweep_done_d;

    logic timeout_hit;
    logic sweep_end;

    // The last permitted wait cycle is the one where the counter still reads TIMEOUT_CYCLES-1.
    assign timeout_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign sweep_end   = (cur_n_q == last_n_q) || ((STOP_ON_OVF != 0) && out_overflow_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cur_n_q        <= '0;
            last_n_q       <= '0;
            tmo_q          <= '0;
            out_valid_q    <= 1'b0;
            out_n_q        <= '0;
            out_result_q   <= '0;
            out_overflow_q <= 1'b0;
            out_count_q    <= '0;
            err_timeout_q  <= 1'b0;
            sweep_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_n_q        <= cur_n_d;
            last_n_q       <= last_n_d;
            tmo_q          <= tmo_d;
            out_valid_q    <= out_valid_d;
            out_n_q        <= out_n_d;
            out_result_q   <= out_result_d;
            out_overflow_q <= out_overflow_d;
            out_count_q    <= out_count_d;
            err_timeout_q  <= err_timeout_d;
            sweep_done_q   <= sweep_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start && (n_first <= n_last)) state_d = ISSUE;
            ISSUE:     state_d = WAIT_LOW;
            WAIT_LOW: begin
                if (timeout_hit)     state_d = IDLE;
                else if (!calc_done) state_d = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (calc_done)        state_d = EMIT;
                else if (timeout_hit) state_d = IDLE;
            end
            EMIT:      if (out_ready) state_d = sweep_end ? IDLE : ISSUE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_n_d        = cur_n_q;
        last_n_d       = last_n_q;
        tmo_d          = tmo_q;
        out_valid_d    = out_valid_q;
        out_n_d        = out_n_q;
        out_result_d   = out_result_q;
        out_overflow_d = out_overflow_q;
        out_count_d    = out_count_q;
        err_timeout_d  = err_timeout_q;
        sweep_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_n_d       = n_first;
                    last_n_d      = n_last;
                    out_count_d   = '0;
                    err_timeout_d = 1'b0;
                    sweep_done_d  = (n_first > n_last);
                end
            end
            ISSUE: tmo_d = '0;
            WAIT_LOW: begin
                tmo_d = tmo_q + TW'(1);
                if (timeout_hit) begin
                    err_timeout_d = 1'b1;
                    sweep_done_d  = 1'b1;
                end
            end
            WAIT_HIGH: begin
                tmo_d = tmo_q + TW'(1);
                if (calc_done) begin
                    out_valid_d    = 1'b1;
                    out_n_d        = cur_n_q;
                    out_result_d   = calc_result;
                    out_overflow_d = calc_overflow;
                end else if (timeout_hit) begin
                    err_timeout_d = 1'b1;
                    sweep_done_d  = 1'b1;
                end
            end
            EMIT: begin
                // End test happens before the increment, so n_last at the top of range never wraps.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_count_d = out_count_q + CW'(1);
                    if (sweep_end) sweep_done_d = 1'b1;
                    else           cur_n_d      = cur_n_q + INPUT_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        calc_go = (state_q == ISSUE);
    end

    assign calc_n       = cur_n_q;
    assign sweep_done   = sweep_done_q;
    assign err_timeout  = err_timeout_q;
    assign out_count    = out_count_q;
    assign out_valid    = out_valid_q;
    assign out_n        = out_n_q;
    assign out_result   = out_result_q;
    assign out_overflow = out_overflow_q;

endmodule
